ws2812b_ring_engine: RTL and testbench
======================================

// Module: ws2812b_ring_engine
// PURPOSE
//  Parametrised WS2812B chain driver for the rotary ring: renders a cursor pattern over
//  NUM_LEDS pixels and serialises it as one GRB frame per refresh request.
//  Sits between the rotary controller (position/mode/refresh) and the single data pin.
//  Successor to the fixed 12-LED driver: generic length, timing, intensity width, display modes.
// PARAMETERS
//  NUM_LEDS      12    pixels in chain (2..255)
//  T0H_CYC       20    high cycles for a 0 bit (0.4 us @ 50 MHz)
//  T1H_CYC       40    high cycles for a 1 bit (0.8 us @ 50 MHz)
//  TBIT_CYC      63    total cycles per bit (>T1H_CYC)
//  RESET_CYC     2750  latch low time after frame (>50 us)
//  INT_W         8     intensity width (<=8); value placed in LSBs of each 8-bit colour byte
// PORTS
//  clk        in   1       system clock
//  res        in   1       synchronous reset, active high
//  refresh    in   1       one-cycle pulse: start (or queue) a frame
//  position   in   8       cursor index 0..NUM_LEDS-1
//  mode       in   2       00 dot, 01 bar, 10 all on, 11 all off
//  colour     in   3       channel enables: [0]=R [1]=G [2]=B
//  intensity  in   INT_W   brightness of every enabled channel of a lit pixel
//  led_dout   out  1       WS2812B serial data
//  busy       out  1       high while a frame or latch period is in progress
// BEHAVIOUR
//  Reset (sync, res=1 at rising edge): led_dout=0, busy=0, pending=0, FSM=IDLE; applies mid-frame.
//  FSM: IDLE -> LOAD -> BIT_HI -> BIT_LO -> (next bit: BIT_HI | frame done: LATCH) -> IDLE/LOAD.
//  IDLE: refresh=1 -> LOAD next cycle; busy=1 from that cycle.
//  LOAD (1 cycle): snapshot position, mode, colour, intensity; pixel=0, bit=23. Inputs changed
//   later do not affect the frame in flight.
//  position >= NUM_LEDS is clamped to NUM_LEDS-1 at snapshot.
//  Pixel i lit: dot i==pos; bar i<=pos; all on always; all off never.
//  Lit pixel byte per channel = enabled ? zero-extended intensity : 8'h00; unlit = 0.
//  Transmit order: pixel 0 first; per pixel G[7:0], R[7:0], B[7:0], MSB first (24 bits).
//  Bit timing: led_dout=1 for T0H_CYC/T1H_CYC cycles, then 0 until TBIT_CYC total; no gaps
//   between bits or pixels. First rising edge of led_dout in cycle after LOAD.
//  Frame length: NUM_LEDS*24*TBIT_CYC cycles of data, then RESET_CYC cycles low (LATCH).
//  LATCH end: pending=1 -> LOAD directly (busy stays 1); else IDLE, busy=0 next cycle.
//  refresh while busy: sets pending (single-depth, extra requests merge); refresh on the
//   same cycle LATCH ends is taken as pending and serviced immediately.
//  Pixel index computed from counters; no per-pixel storage (area bound for TT tile).
// CONFIGURATION
//  RING_TAIL_EN defined: in dot mode, pixels (pos-1) and (pos-2) modulo NUM_LEDS are also lit,
//   at intensity>>1 and intensity>>2 respectively; wraps (pos=0 -> tail on N-1, N-2).
//   Bar/all modes unchanged. If N=2, pos-2 == pos: pixel keeps full intensity.
//  RING_TAIL_EN undefined: dot mode lights only pixel pos; no tail logic synthesised.
// TESTING  (bench params NUM_LEDS=4, T0H=2, T1H=4, TBIT=6, RESET=10, INT_W=8)
//  Reset then idle 20 cycles -> led_dout=0, busy=0 throughout.
//  refresh, mode=00 pos=2 colour=3'b001 int=8'hA5 -> 96 bits, pixel2 = G00 RA5 B00, others 0;
//   busy high 96*6+10+1 cycles; high pulses 2 cycles (0) / 4 cycles (1).
//  mode=01 pos=9 colour=3'b111 int=8'h01 -> clamp to pos 3: all 4 pixels 010101.
//  refresh asserted 3x during frame -> exactly one further frame, busy never drops between.
//  res=1 mid-bit (high phase) -> led_dout=0 and busy=0 next cycle; new refresh starts clean frame.
//  RING_TAIL_EN, mode=00 pos=0 colour=3'b010 int=8'h80 -> G: pix0 80, pix3 40, pix2 20, pix1 00.

Source files
------------

// File: rtl/ws2812b_ring_engine.sv
// ws2812b_ring_engine: renders a cursor pattern (dot/bar/all on/all off) over a
// chain of WS2812B pixels and serialises one GRB frame per refresh request.
// Optional feature macro: RING_TAIL_EN (dot mode lights two dimmed trailing pixels).
module ws2812b_ring_engine #(
    parameter int unsigned NUM_LEDS  = 12,
    parameter int unsigned T0H_CYC   = 20,
    parameter int unsigned T1H_CYC   = 40,
    parameter int unsigned TBIT_CYC  = 63,
    parameter int unsigned RESET_CYC = 2750,
    parameter int unsigned INT_W     = 8
) (
    input  logic             clk,
    input  logic             res,
    input  logic             refresh,
    input  logic [7:0]       position,
    input  logic [1:0]       mode,
    input  logic [2:0]       colour,
    input  logic [INT_W-1:0] intensity,
    output logic             led_dout,
    output logic             busy
);

    localparam int unsigned CNT_MAX  = (TBIT_CYC > RESET_CYC) ? TBIT_CYC : RESET_CYC;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX);
    localparam logic [7:0]  LAST_PIX = 8'(NUM_LEDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_BIT_HI,
        S_BIT_LO,
        S_LATCH
    } state_t;

    state_t             r_state;
    logic [7:0]         r_pos;
    logic [1:0]         r_mode;
    logic [2:0]         r_col;
    logic [INT_W-1:0]   r_int;
    logic [7:0]         r_pix;
    logic [4:0]         r_bit;
    logic [CNT_W-1:0]   r_cyc;
    logic               r_pending;
    logic               r_dout;
    logic               r_busy;

    logic [7:0]         w_pos_clamp;
    logic [INT_W-1:0]   w_level;
    logic [7:0]         w_byte;
    logic               w_chan_en;
    logic               w_bit;
    logic [CNT_W-1:0]   w_high_last;
    logic               w_last_bit;

    assign led_dout = r_dout;
    assign busy     = r_busy;

    // Out-of-range cursor positions collapse onto the last pixel
    assign w_pos_clamp = (position >= 8'(NUM_LEDS)) ? LAST_PIX : position;

`ifdef RING_TAIL_EN
    logic [7:0] w_tail1;
    logic [7:0] w_tail2;

    // Trailing pixel indices, wrapping around the ring
    assign w_tail1 = (r_pos == 8'd0) ? LAST_PIX : r_pos - 8'd1;
    assign w_tail2 = (r_pos >= 8'd2) ? r_pos - 8'd2 : r_pos + 8'(NUM_LEDS - 2);
`endif

    // Brightness of the pixel currently being shifted out
    always_comb begin
        w_level = '0;
        case (r_mode)
            2'b00: begin
                if (r_pix == r_pos) begin
                    w_level = r_int;
                end
`ifdef RING_TAIL_EN
                else if (r_pix == w_tail1) begin
                    w_level = r_int >> 1;
                end else if (r_pix == w_tail2) begin
                    w_level = r_int >> 2;
                end
`endif
            end
            2'b01: begin
                if (r_pix <= r_pos) begin
                    w_level = r_int;
                end
            end
            2'b10:   w_level = r_int;
            default: w_level = '0;
        endcase
    end

    // Channel select from bit index: 23..16 G, 15..8 R, 7..0 B
    always_comb begin
        w_chan_en = 1'b0;
        case (r_bit[4:3])
            2'b10:   w_chan_en = r_col[1];
            2'b01:   w_chan_en = r_col[0];
            2'b00:   w_chan_en = r_col[2];
            default: w_chan_en = 1'b0;
        endcase
    end

    assign w_byte      = 8'(w_level);
    assign w_bit       = w_chan_en & w_byte[r_bit[2:0]];
    assign w_high_last = w_bit ? CNT_W'(T1H_CYC - 1) : CNT_W'(T0H_CYC - 1);
    assign w_last_bit  = (r_bit == 5'd0) && (r_pix == LAST_PIX);

    // Frame sequencer: snapshot, per-bit high/low phases, latch gap, queued refresh
    always_ff @(posedge clk) begin
        if (res) begin
            r_state   <= S_IDLE;
            r_dout    <= 1'b0;
            r_busy    <= 1'b0;
            r_pending <= 1'b0;
            r_cyc     <= '0;
            r_pix     <= '0;
            r_bit     <= '0;
        end else begin
            if (refresh && (r_state != S_IDLE)) begin
                r_pending <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (refresh) begin
                        r_state <= S_LOAD;
                        r_busy  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_pos   <= w_pos_clamp;
                    r_mode  <= mode;
                    r_col   <= colour;
                    r_int   <= intensity;
                    r_pix   <= 8'd0;
                    r_bit   <= 5'd23;
                    r_cyc   <= '0;
                    r_dout  <= 1'b1;
                    r_state <= S_BIT_HI;
                end
                S_BIT_HI: begin
                    r_cyc <= r_cyc + CNT_W'(1);
                    if (r_cyc == w_high_last) begin
                        r_dout  <= 1'b0;
                        r_state <= S_BIT_LO;
                    end
                end
                S_BIT_LO: begin
                    if (r_cyc == CNT_W'(TBIT_CYC - 1)) begin
                        r_cyc <= '0;
                        if (w_last_bit) begin
                            r_state <= S_LATCH;
                        end else begin
                            r_dout  <= 1'b1;
                            r_state <= S_BIT_HI;
                            if (r_bit == 5'd0) begin
                                r_bit <= 5'd23;
                                r_pix <= r_pix + 8'd1;
                            end else begin
                                r_bit <= r_bit - 5'd1;
                            end
                        end
                    end else begin
                        r_cyc <= r_cyc + CNT_W'(1);
                    end
                end
                S_LATCH: begin
                    if (r_cyc == CNT_W'(RESET_CYC - 1)) begin
                        r_cyc <= '0;
                        if (r_pending || refresh) begin
                            r_pending <= 1'b0;
                            r_state   <= S_LOAD;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cyc <= r_cyc + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_dout  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812b_ring_engine.sv
// Directed bench for ws2812b_ring_engine: decodes the serial stream back into
// GRB words and checks busy length, pulse widths, clamping, queuing and reset.
module tb_ws2812b_ring_engine;

    localparam int unsigned N          = 4;
    localparam int          FRAME_BUSY = 1 + 96 * 6 + 10;

    logic       clk = 1'b0;
    logic       res;
    logic       refresh;
    logic [7:0] position;
    logic [1:0] mode;
    logic [2:0] colour;
    logic [7:0] intensity;
    logic       led_dout;
    logic       busy;

    logic [7:0] nxt_position;
    logic [1:0] nxt_mode;
    logic [2:0] nxt_colour;
    logic [7:0] nxt_intensity;

    bit          samp[$];
    int          busy_len;
    int          bad_pulse;
    logic        timed_out;
    logic [23:0] got_px[N];

    int vectors     = 0;
    int miscompares = 0;

    ws2812b_ring_engine #(
        .NUM_LEDS (N),
        .T0H_CYC  (2),
        .T1H_CYC  (4),
        .TBIT_CYC (6),
        .RESET_CYC(10),
        .INT_W    (8)
    ) dut (
        .clk      (clk),
        .res      (res),
        .refresh  (refresh),
        .position (position),
        .mode     (mode),
        .colour   (colour),
        .intensity(intensity),
        .led_dout (led_dout),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse refresh at the current negedge, record led_dout while busy; extra refresh
    // pulses at negedge indices e0..e2; inputs switch to nxt_* once the frame is loaded.
    task automatic run_watch(input int e0, input int e1, input int e2);
        samp.delete();
        busy_len  = 0;
        timed_out = 1'b1;
        refresh   = 1'b1;
        for (int i = 1; i < 5000; i++) begin
            @(negedge clk);
            if (!busy) begin
                timed_out = 1'b0;
                break;
            end
            samp.push_back(led_dout);
            busy_len++;
            refresh = (i == e0) || (i == e1) || (i == e2);
            if (i == 2) begin
                position  = nxt_position;
                mode      = nxt_mode;
                colour    = nxt_colour;
                intensity = nxt_intensity;
            end
        end
        refresh = 1'b0;
    endtask

    // Rebuild the four GRB words of a frame starting at sample offset off
    task automatic decode(input int off);
        int h;
        bit bv;
        for (int p = 0; p < N; p++) got_px[p] = '0;
        bad_pulse = 0;
        if (samp.size() < off + FRAME_BUSY) begin
            bad_pulse = 1;
            return;
        end
        if (samp[off]) bad_pulse++;
        for (int p = 0; p < N; p++) begin
            for (int k = 0; k < 24; k++) begin
                int base;
                base = off + 1 + (p * 24 + k) * 6;
                h = 0;
                for (int j = 0; j < 6; j++) if (samp[base + j]) h++;
                for (int j = 0; j < 6; j++) if (samp[base + j] != (j < h)) bad_pulse++;
                bv = 1'b0;
                if (h == 4) bv = 1'b1;
                else if (h != 2) bad_pulse++;
                got_px[p] = {got_px[p][22:0], bv};
            end
        end
        for (int j = 0; j < 10; j++) if (samp[off + 577 + j]) bad_pulse++;
    endtask

    task automatic check_frame(input string tag, input int off, input logic [23:0] e0,
                               input logic [23:0] e1, input logic [23:0] e2, input logic [23:0] e3);
        decode(off);
        check({tag, "_pulses"}, 32'(bad_pulse), 32'd0);
        check({tag, "_px0"}, 32'(got_px[0]), 32'(e0));
        check({tag, "_px1"}, 32'(got_px[1]), 32'(e1));
        check({tag, "_px2"}, 32'(got_px[2]), 32'(e2));
        check({tag, "_px3"}, 32'(got_px[3]), 32'(e3));
    endtask

    initial begin
        res = 1'b1; refresh = 1'b0;
        position = '0; mode = '0; colour = '0; intensity = '0;
        nxt_position = '0; nxt_mode = 2'b11; nxt_colour = '0; nxt_intensity = '0;
        repeat (3) @(negedge clk);
        res = 1'b0;

        // Idle after reset
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_dout", 32'(led_dout), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
        end

        // Dot, red only, inputs scrambled after load
        position = 8'd2; mode = 2'b00; colour = 3'b001; intensity = 8'hA5;
        nxt_position = 8'd0; nxt_mode = 2'b10; nxt_colour = 3'b111; nxt_intensity = 8'hFF;
        run_watch(-1, -1, -1);
        check("dot_timeout", 32'(timed_out), 32'd0);
        check("dot_busy_len", 32'(busy_len), 32'(FRAME_BUSY));
        check("dot_dout_after", 32'(led_dout), 32'd0);
`ifdef RING_TAIL_EN
        check_frame("dot", 0, 24'h002900, 24'h005200, 24'h00A500, 24'h000000);
`else
        check_frame("dot", 0, 24'h000000, 24'h000000, 24'h00A500, 24'h000000);
`endif

        // All on blue, three refreshes mid-frame merge into one follow-up frame
        position = 8'd0; mode = 2'b10; colour = 3'b100; intensity = 8'h3C;
        nxt_position = 8'd1; nxt_mode = 2'b00; nxt_colour = 3'b010; nxt_intensity = 8'h7F;
        run_watch(100, 300, 500);
        check("pend_timeout", 32'(timed_out), 32'd0);
        check("pend_busy_len", 32'(busy_len), 32'(2 * FRAME_BUSY));
        check_frame("pend_f1", 0, 24'h00003C, 24'h00003C, 24'h00003C, 24'h00003C);
`ifdef RING_TAIL_EN
        check_frame("pend_f2", FRAME_BUSY, 24'h3F0000, 24'h7F0000, 24'h000000, 24'h1F0000);
`else
        check_frame("pend_f2", FRAME_BUSY, 24'h000000, 24'h7F0000, 24'h000000, 24'h000000);
`endif

        // Bar with out-of-range position; refresh on the last latch cycle chains a dot at 0
        position = 8'd9; mode = 2'b01; colour = 3'b111; intensity = 8'h01;
        nxt_position = 8'd0; nxt_mode = 2'b00; nxt_colour = 3'b010; nxt_intensity = 8'h80;
        run_watch(FRAME_BUSY, -1, -1);
        check("chain_timeout", 32'(timed_out), 32'd0);
        check("chain_busy_len", 32'(busy_len), 32'(2 * FRAME_BUSY));
        check_frame("bar", 0, 24'h010101, 24'h010101, 24'h010101, 24'h010101);
`ifdef RING_TAIL_EN
        check_frame("tail", FRAME_BUSY, 24'h800000, 24'h000000, 24'h200000, 24'h400000);
`else
        check_frame("tail", FRAME_BUSY, 24'h800000, 24'h000000, 24'h000000, 24'h000000);
`endif

        // Reset during the high phase of the first bit
        position = 8'd0; mode = 2'b10; colour = 3'b010; intensity = 8'h11;
        nxt_position = 8'd0; nxt_mode = 2'b10; nxt_colour = 3'b010; nxt_intensity = 8'h11;
        refresh = 1'b1;
        @(negedge clk);
        refresh = 1'b0;
        check("rst_load_busy", 32'(busy), 32'd1);
        check("rst_load_dout", 32'(led_dout), 32'd0);
        @(negedge clk);
        check("rst_hi_dout", 32'(led_dout), 32'd1);
        res = 1'b1;
        @(negedge clk);
        check("rst_dout", 32'(led_dout), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        res = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rst_idle_busy", 32'(busy), 32'd0);
            check("rst_idle_dout", 32'(led_dout), 32'd0);
        end
        run_watch(-1, -1, -1);
        check("post_rst_timeout", 32'(timed_out), 32'd0);
        check("post_rst_busy_len", 32'(busy_len), 32'(FRAME_BUSY));
        check_frame("post_rst", 0, 24'h110000, 24'h110000, 24'h110000, 24'h110000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
